sram_qpi_engine: RTL and testbench



---
 rtl/sram_qpi_engine.sv | 260 ++++++++++++++++++++++++++
 tb/tb_sram_qpi_engine.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_qpi_engine.sv
// Quad-SPI SRAM transaction sequencer: command, 24-bit address, dummy nibbles,
// then a read or write byte burst, two clocks per nibble on auto_clock.
module sram_qpi_engine #(
    parameter logic [7:0]  CMD_READ       = 8'h03,
    parameter logic [7:0]  CMD_WRITE      = 8'h02,
    parameter int unsigned DUMMY_NIBBLES  = 2,
    parameter int unsigned CS_HIGH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        write,
    input  logic [23:0] address,
    input  logic [7:0]  length,
    input  logic [7:0]  wr_data,
    input  logic        wr_data_valid,
    output logic        wr_data_ready,
    output logic [7:0]  rd_data,
    output logic        rd_data_valid,
    output logic        busy,
    output logic        done,
    output logic        qpi_cs_n,
    output logic        auto_clock,
    output logic        qpi_direction,
    output logic [3:0]  qpi_output,
    input  logic [3:0]  qpi_sio_in
);

    localparam int unsigned CNT_W  = (CS_HIGH_CYCLES > 16) ? $clog2(CS_HIGH_CYCLES) : 4;
    localparam int unsigned BCNT_W = 9;
    localparam int unsigned SREG_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RDATA,
        WDATA,
        CSHIGH
    } state_t;

    state_t              state_q, state_d;
    logic                phase_q, phase_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [SREG_W-1:0]   sreg_q, sreg_d;
    logic [3:0]          rd_hi_q, rd_hi_d;
    logic [3:0]          wr_lo_q, wr_lo_d;
    logic                is_write_q, is_write_d;

    logic                cs_n_d;
    logic                auto_d;
    logic                dir_d;
    logic [3:0]          out_d;
    logic                busy_d;
    logic                done_d;
    logic                ready_d;
    logic                rd_valid_d;
    logic [7:0]          rd_data_d;

    // State and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            phase_q       <= 1'b0;
            cnt_q         <= '0;
            bcnt_q        <= '0;
            sreg_q        <= '0;
            rd_hi_q       <= '0;
            wr_lo_q       <= '0;
            is_write_q    <= 1'b0;
            qpi_cs_n      <= 1'b1;
            auto_clock    <= 1'b0;
            qpi_direction <= 1'b0;
            qpi_output    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            wr_data_ready <= 1'b0;
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            cnt_q         <= cnt_d;
            bcnt_q        <= bcnt_d;
            sreg_q        <= sreg_d;
            rd_hi_q       <= rd_hi_d;
            wr_lo_q       <= wr_lo_d;
            is_write_q    <= is_write_d;
            qpi_cs_n      <= cs_n_d;
            auto_clock    <= auto_d;
            qpi_direction <= dir_d;
            qpi_output    <= out_d;
            busy          <= busy_d;
            done          <= done_d;
            wr_data_ready <= ready_d;
            rd_data_valid <= rd_valid_d;
            rd_data       <= rd_data_d;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        bcnt_d     = bcnt_q;
        sreg_d     = sreg_q;
        rd_hi_d    = rd_hi_q;
        wr_lo_d    = wr_lo_q;
        is_write_d = is_write_q;
        cs_n_d     = qpi_cs_n;
        auto_d     = 1'b0;
        dir_d      = qpi_direction;
        out_d      = qpi_output;
        busy_d     = busy;
        done_d     = 1'b0;
        ready_d    = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data;

        case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                dir_d  = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    state_d    = CMD;
                    phase_d    = 1'b0;
                    cnt_d      = '0;
                    is_write_d = write;
                    sreg_d     = {(write ? CMD_WRITE : CMD_READ), address};
                    bcnt_d     = (length == 8'd0) ? BCNT_W'(256) : {1'b0, length};
                    cs_n_d     = 1'b0;
                    dir_d      = 1'b1;
                    busy_d     = 1'b1;
                    out_d      = write ? CMD_WRITE[7:4] : CMD_READ[7:4];
                end
            end

            // Command and address share a shift register, MSB nibble first
            CMD, ADDR: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    auto_d  = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    sreg_d  = {sreg_q[27:0], 4'h0};
                    out_d   = sreg_q[27:24];
                    if (state_q == CMD && cnt_q == CNT_W'(1)) begin
                        state_d = ADDR;
                        cnt_d   = '0;
                    end else if (state_q == ADDR && cnt_q == CNT_W'(5)) begin
                        cnt_d = '0;
                        out_d = qpi_output;
                        if (is_write_q) begin
                            state_d = WDATA;
                            ready_d = 1'b1;
                        end else begin
                            state_d = DUMMY;
                            dir_d   = 1'b0;
                        end
                    end
                end
            end

            DUMMY: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    auto_d  = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DUMMY_NIBBLES - 1)) begin
                        state_d = RDATA;
                        cnt_d   = '0;
                    end
                end
            end

            // cnt_q selects high (0) or low (1) nibble of the current byte
            RDATA: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    auto_d  = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (cnt_q == CNT_W'(0)) begin
                        rd_hi_d = qpi_sio_in;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        rd_data_d  = {rd_hi_q, qpi_sio_in};
                        rd_valid_d = 1'b1;
                        cnt_d      = '0;
                        bcnt_d     = bcnt_q - BCNT_W'(1);
                        if (bcnt_q == BCNT_W'(1)) begin
                            state_d = CSHIGH;
                            cs_n_d  = 1'b1;
                            dir_d   = 1'b0;
                        end
                    end
                end
            end

            // High-nibble phase 0 doubles as the handshake wait; stalls hold auto_clock low
            WDATA: begin
                if (cnt_q == CNT_W'(0) && !phase_q) begin
                    if (wr_data_valid && wr_data_ready) begin
                        out_d   = wr_data[7:4];
                        wr_lo_d = wr_data[3:0];
                        phase_d = 1'b1;
                        auto_d  = 1'b1;
                    end else begin
                        ready_d = 1'b1;
                    end
                end else if (!phase_q) begin
                    phase_d = 1'b1;
                    auto_d  = 1'b1;
                end else if (cnt_q == CNT_W'(0)) begin
                    phase_d = 1'b0;
                    cnt_d   = CNT_W'(1);
                    out_d   = wr_lo_q;
                end else begin
                    phase_d = 1'b0;
                    cnt_d   = '0;
                    bcnt_d  = bcnt_q - BCNT_W'(1);
                    if (bcnt_q == BCNT_W'(1)) begin
                        state_d = CSHIGH;
                        cs_n_d  = 1'b1;
                        dir_d   = 1'b0;
                    end else begin
                        ready_d = 1'b1;
                    end
                end
            end

            CSHIGH: begin
                cs_n_d = 1'b1;
                dir_d  = 1'b0;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(CS_HIGH_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                dir_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_qpi_engine.sv
// Bench for sram_qpi_engine: SRAM-side monitor, write-data feeder with stalls,
// and a transaction-level model of nibble stream, handshakes and timing.
module tb_sram_qpi_engine;

    localparam int unsigned DUMMY = 2;
    localparam int unsigned CSH   = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        write;
    logic [23:0] address;
    logic [7:0]  length;
    logic [7:0]  wr_data;
    logic        wr_data_valid;
    logic        wr_data_ready;
    logic [7:0]  rd_data;
    logic        rd_data_valid;
    logic        busy;
    logic        done;
    logic        qpi_cs_n;
    logic        auto_clock;
    logic        qpi_direction;
    logic [3:0]  qpi_output;
    logic [3:0]  qpi_sio_in;

    sram_qpi_engine dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .write         (write),
        .address       (address),
        .length        (length),
        .wr_data       (wr_data),
        .wr_data_valid (wr_data_valid),
        .wr_data_ready (wr_data_ready),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .busy          (busy),
        .done          (done),
        .qpi_cs_n      (qpi_cs_n),
        .auto_clock    (auto_clock),
        .qpi_direction (qpi_direction),
        .qpi_output    (qpi_output),
        .qpi_sio_in    (qpi_sio_in)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor state
    logic [3:0] nib_q[$];
    logic       dir_q[$];
    logic [7:0] rd_q[$];
    int  cs_low_cnt, done_cnt, stall_cycles, stall_bad, clk_bad;
    int  cyc, last_cs_rise, last_done, txn_edges, mon_idx;
    logic prev_auto, prev_cs, hs_seen;

    // Stimulus data shared with the SRAM model and the feeder
    logic [7:0] sio_bytes [256];
    logic [7:0] wr_bytes  [256];
    logic [7:0] wq[$];
    int         dq[$];
    logic       have_cur;
    logic [7:0] cur_b;
    int         cur_d;
    int         n_xfer;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SRAM-side monitor and read-data source, sampled on the falling clock edge
    initial begin
        prev_auto = 1'b0; prev_cs = 1'b1; hs_seen = 1'b0; qpi_sio_in = 4'h0;
        cs_low_cnt = 0; done_cnt = 0; stall_cycles = 0; stall_bad = 0; clk_bad = 0;
        cyc = 0; last_cs_rise = 0; last_done = 0; txn_edges = 0; mon_idx = 0;
        forever begin
            @(negedge clock);
            cyc++;
            if (auto_clock && !prev_auto) begin
                nib_q.push_back(qpi_output);
                dir_q.push_back(qpi_direction);
                txn_edges++;
            end
            if (qpi_cs_n) txn_edges = 0;
            if (!qpi_cs_n) cs_low_cnt++;
            if (qpi_cs_n && !prev_cs) last_cs_rise = cyc;
            if (done) begin done_cnt++; last_done = cyc; end
            if (rd_data_valid) rd_q.push_back(rd_data);
            if (qpi_cs_n && auto_clock) clk_bad++;
            if (wr_data_ready && !wr_data_valid) begin
                stall_cycles++;
                if (auto_clock || qpi_cs_n) stall_bad++;
            end
            hs_seen = wr_data_valid && wr_data_ready;
            if (!auto_clock) begin
                mon_idx = txn_edges - 8 - int'(DUMMY);
                if (mon_idx >= 0 && mon_idx < 512)
                    qpi_sio_in = mon_idx[0] ? sio_bytes[mon_idx >> 1][3:0]
                                            : sio_bytes[mon_idx >> 1][7:4];
            end
            prev_auto = auto_clock;
            prev_cs   = qpi_cs_n;
        end
    end

    // Write-data feeder: each byte is withheld for its delay in ready cycles
    initial begin
        wr_data_valid = 1'b0; wr_data = 8'h00; have_cur = 1'b0;
        cur_b = 8'h00; cur_d = 0; n_xfer = 0;
        forever begin
            @(posedge clock); #1;
            if (!reset_n) begin
                wr_data_valid = 1'b0;
                have_cur = 1'b0;
            end else begin
                if (hs_seen) begin
                    n_xfer++;
                    wr_data_valid = 1'b0;
                    have_cur = 1'b0;
                end
                if (!have_cur && wq.size() > 0) begin
                    cur_b = wq.pop_front();
                    cur_d = dq.pop_front();
                    have_cur = 1'b1;
                end
                if (have_cur && !wr_data_valid) begin
                    if (cur_d == 0) begin
                        wr_data = cur_b;
                        wr_data_valid = 1'b1;
                    end else if (wr_data_ready) begin
                        cur_d--;
                    end
                end
            end
        end
    end

    task automatic run_txn(input logic wr, input logic [23:0] addr, input int len,
                           input int stall_idx, input int stall_len, input int poke_at,
                           input string tag);
        int nb, rb, xb, cb, db, sb, edges, stall, bad_dir, c;
        logic got, poked;
        logic [31:0] hdr;
        stall = (wr && stall_idx < len) ? stall_len : 0;
        edges = 8 + (wr ? 0 : int'(DUMMY)) + 2 * len;
        if (wr)
            for (int i = 0; i < len; i++) begin
                wq.push_back(wr_bytes[i]);
                dq.push_back((i == stall_idx) ? stall_len : 0);
            end
        repeat (2) @(posedge clock);
        #1;
        nb = nib_q.size(); rb = rd_q.size(); xb = n_xfer; cb = cs_low_cnt;
        db = done_cnt; sb = stall_cycles;
        start = 1'b1; write = wr; address = addr; length = 8'(len);
        @(posedge clock); #1;
        start = 1'b0; write = 1'($urandom); address = 24'($urandom); length = 8'($urandom);
        check({tag, ":busy_rise"}, 32'(busy), 32'd1);
        check({tag, ":cs_fall"}, 32'(qpi_cs_n), 32'd0);
        check({tag, ":dir_start"}, 32'(qpi_direction), 32'd1);
        check({tag, ":cmd_hi"}, 32'(qpi_output), 32'h0);

        got = 1'b0; poked = 1'b0;
        for (c = 0; c < 100 + 4 * len + stall && !got; c++) begin
            @(posedge clock); #1;
            if (poked) begin
                start = 1'b0;
                poked = 1'b0;
                check({tag, ":poke_busy"}, 32'(busy), 32'd1);
            end
            if (poke_at > 0 && c == poke_at) begin
                start = 1'b1;
                poked = 1'b1;
            end
            if (done) got = 1'b1;
        end
        start = 1'b0;
        check({tag, ":done_seen"}, 32'(got), 32'd1);
        check({tag, ":busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clock); #1;

        check({tag, ":edges"}, 32'(nib_q.size() - nb), 32'(edges));
        hdr = {(wr ? 8'h02 : 8'h03), addr};
        for (int i = 0; i < 8; i++)
            if (nb + i < nib_q.size())
                check({tag, ":hdr_nib"}, 32'(nib_q[nb + i]), 32'(hdr[31 - 4 * i -: 4]));
        bad_dir = 0;
        for (int i = 0; i < edges && nb + i < dir_q.size(); i++)
            if (dir_q[nb + i] !== ((wr || i < 8) ? 1'b1 : 1'b0)) bad_dir++;
        check({tag, ":direction"}, 32'(bad_dir), 32'd0);
        if (wr) begin
            for (int b = 0; b < len; b++)
                if (nb + 9 + 2 * b < nib_q.size()) begin
                    check({tag, ":wr_hi"}, 32'(nib_q[nb + 8 + 2 * b]), 32'(wr_bytes[b][7:4]));
                    check({tag, ":wr_lo"}, 32'(nib_q[nb + 9 + 2 * b]), 32'(wr_bytes[b][3:0]));
                end
            check({tag, ":xfers"}, 32'(n_xfer - xb), 32'(len));
            check({tag, ":stall_cycles"}, 32'(stall_cycles - sb), 32'(stall));
        end else begin
            check({tag, ":rd_count"}, 32'(rd_q.size() - rb), 32'(len));
            for (int b = 0; b < len && rb + b < rd_q.size(); b++)
                check({tag, ":rd_byte"}, 32'(rd_q[rb + b]), 32'(sio_bytes[b]));
        end
        check({tag, ":cs_low"}, 32'(cs_low_cnt - cb), 32'(2 * edges + stall));
        check({tag, ":done_after_cs"}, 32'(last_done - last_cs_rise), 32'(CSH));
        check({tag, ":done_count"}, 32'(done_cnt - db), 32'd1);
        @(posedge clock); #1;
        check({tag, ":done_pulse"}, 32'(done), 32'd0);
    endtask

    int db0;
    int rlen, rstall;

    initial begin
        reset_n = 1'b0; start = 1'b0; write = 1'b0; address = 24'h0; length = 8'h0;
        for (int i = 0; i < 256; i++) begin
            sio_bytes[i] = 8'($urandom);
            wr_bytes[i]  = 8'($urandom);
        end
        repeat (3) @(posedge clock);
        #1;
        check("rst:cs_n", 32'(qpi_cs_n), 32'd1);
        check("rst:auto_clock", 32'(auto_clock), 32'd0);
        check("rst:direction", 32'(qpi_direction), 32'd0);
        check("rst:qpi_output", 32'(qpi_output), 32'd0);
        check("rst:busy", 32'(busy), 32'd0);
        check("rst:done", 32'(done), 32'd0);
        check("rst:wr_ready", 32'(wr_data_ready), 32'd0);
        check("rst:rd_valid", 32'(rd_data_valid), 32'd0);
        check("rst:rd_data", 32'(rd_data), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        wr_bytes[0] = 8'hA5;
        run_txn(1'b1, 24'h012345, 1, 0, 0, -1, "wr_a5");

        sio_bytes[0] = 8'h3C; sio_bytes[1] = 8'hD7;
        run_txn(1'b0, 24'h000010, 2, 0, 0, -1, "rd_3c_d7");

        for (int i = 0; i < 3; i++) wr_bytes[i] = 8'($urandom);
        run_txn(1'b1, 24'($urandom), 3, 1, 7, -1, "wr_stall");

        for (int i = 0; i < 256; i++) sio_bytes[i] = 8'($urandom);
        run_txn(1'b0, 24'($urandom), 256, 0, 0, 300, "rd_256");

        for (int i = 0; i < 4; i++) wr_bytes[i] = 8'($urandom);
        run_txn(1'b1, 24'hFFFFFF, 4, 0, 0, -1, "wr_addr_max");

        // Reset during the address phase of a write
        for (int i = 0; i < 4; i++) wr_bytes[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) begin wq.push_back(wr_bytes[i]); dq.push_back(0); end
        repeat (2) @(posedge clock);
        #1;
        db0 = done_cnt;
        start = 1'b1; write = 1'b1; address = 24'hABCDEF; length = 8'd4;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        reset_n = 1'b0;
        wq.delete();
        dq.delete();
        #1;
        check("abort:cs_n", 32'(qpi_cs_n), 32'd1);
        check("abort:auto_clock", 32'(auto_clock), 32'd0);
        check("abort:busy", 32'(busy), 32'd0);
        check("abort:wr_ready", 32'(wr_data_ready), 32'd0);
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("abort:no_done", 32'(done_cnt - db0), 32'd0);
        for (int i = 0; i < 5; i++) wr_bytes[i] = 8'($urandom);
        run_txn(1'b1, 24'h13579B, 5, 2, 3, -1, "after_abort");

        for (int t = 0; t < 6; t++) begin
            rlen   = int'($urandom_range(1, 6));
            rstall = int'($urandom_range(0, 5));
            for (int i = 0; i < rlen; i++) begin
                wr_bytes[i]  = 8'($urandom);
                sio_bytes[i] = 8'($urandom);
            end
            run_txn(1'($urandom), 24'($urandom), rlen,
                    int'($urandom_range(0, rlen - 1)), rstall, -1, "random");
        end

        check("glob:auto_clock_with_cs_high", 32'(clk_bad), 32'd0);
        check("glob:stall_activity", 32'(stall_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
